// File: rtl/ccu_ctrl_mu_arbiter.sv
// Round-robin arbiter sharing the CCU control memory unit between NoReq requesters,
// with selection lock until grant and starvation-driven urgent priority.

package ccu_ctrl_pkg;
  typedef enum logic [1:0] {
    MU_NOP   = 2'd0,
    MU_READ  = 2'd1,
    MU_WRITE = 2'd2,
    MU_FLUSH = 2'd3
  } mu_op_e;
endpackage

module ccu_ctrl_mu_arbiter
  import ccu_ctrl_pkg::*;
#(
  parameter int unsigned NoReq        = 2,
  parameter int unsigned NoMstPorts   = 4,
  parameter int unsigned StarveLimit  = 16,
  parameter bit          PerfCounters = 1'b1,
  parameter type         slv_req_t    = logic,
  localparam int unsigned MstIdxBits  = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NoReq-1:0]      req_i,
  input  mu_op_e                op_i              [NoReq],
  input  slv_req_t              holder_i          [NoReq],
  input  logic [MstIdxBits-1:0] first_responder_i [NoReq],
  output logic [NoReq-1:0]      gnt_o,
  output logic                  mu_req_o,
  output mu_op_e                mu_op_o,
  output slv_req_t              ccu_req_holder_o,
  output logic [MstIdxBits-1:0] first_responder_o,
  input  logic                  mu_gnt_i,
  output logic [2:0]            perf_evt_o
);

  localparam int unsigned IdxW = (NoReq > 1) ? $clog2(NoReq) : 1;
  localparam int unsigned CntW = (StarveLimit > 0) ? $clog2(StarveLimit + 1) : 1;

  logic [IdxW-1:0] rr_ptr_q;
  logic            lock_q;
  logic [IdxW-1:0] sel_q;
  logic [CntW-1:0] wait_cnt_q [NoReq];

  logic [NoReq-1:0] w_urgent;
  logic             w_found_urg;
  logic             w_found_req;
  logic [IdxW-1:0]  w_idx_urg;
  logic [IdxW-1:0]  w_idx_req;
  logic [IdxW-1:0]  w_sel;
  logic             w_active;
  logic             w_grant;

  // Index `off` positions after `base`, wrapping modulo NoReq.
  function automatic logic [IdxW-1:0] rot_idx(input logic [IdxW-1:0] base,
                                              input int unsigned     off);
    rot_idx = IdxW'((32'(base) + off) % NoReq);
  endfunction

  always_comb begin
    w_urgent = '0;
    for (int unsigned i = 0; i < NoReq; i++) begin
      w_urgent[i] = (StarveLimit != 0) && req_i[i] &&
                    (wait_cnt_q[i] == CntW'(StarveLimit));
    end
  end

  // First urgent and first requesting index at or after the pointer.
  always_comb begin
    w_found_urg = 1'b0;
    w_found_req = 1'b0;
    w_idx_urg   = '0;
    w_idx_req   = '0;
    for (int unsigned k = 0; k < NoReq; k++) begin
      if (!w_found_urg && w_urgent[rot_idx(rr_ptr_q, k)]) begin
        w_found_urg = 1'b1;
        w_idx_urg   = rot_idx(rr_ptr_q, k);
      end
      if (!w_found_req && req_i[rot_idx(rr_ptr_q, k)]) begin
        w_found_req = 1'b1;
        w_idx_req   = rot_idx(rr_ptr_q, k);
      end
    end
  end

  assign w_sel    = lock_q ? sel_q : (w_found_urg ? w_idx_urg : w_idx_req);
  assign w_active = req_i[w_sel];
  assign w_grant  = w_active & mu_gnt_i;
  assign mu_req_o = w_active;

  always_comb begin
    gnt_o             = '0;
    mu_op_o           = MU_NOP;
    ccu_req_holder_o  = '0;
    first_responder_o = '0;
    if (w_active) begin
      gnt_o[w_sel]      = mu_gnt_i;
      mu_op_o           = op_i[w_sel];
      ccu_req_holder_o  = holder_i[w_sel];
      first_responder_o = first_responder_i[w_sel];
    end
  end

  assign perf_evt_o = PerfCounters ?
                      {($countones(req_i) > 1), (w_active & ~mu_gnt_i),
                       (w_grant & w_urgent[w_sel])} : 3'b000;

  // A dropped locked request also releases the lock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      lock_q   <= 1'b0;
      sel_q    <= '0;
    end else if (w_grant) begin
      lock_q   <= 1'b0;
      rr_ptr_q <= rot_idx(w_sel, 1);
    end else if (w_active) begin
      lock_q   <= 1'b1;
      sel_q    <= w_sel;
    end else begin
      lock_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NoReq; i++) wait_cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NoReq; i++) begin
        if (gnt_o[i] || !req_i[i]) begin
          wait_cnt_q[i] <= '0;
        end else if (wait_cnt_q[i] != CntW'(StarveLimit)) begin
          wait_cnt_q[i] <= wait_cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  a_lock_req_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                       lock_q |-> req_i[sel_q])
    else $warning("ccu_ctrl_mu_arbiter: locked requester %0d dropped its request", sel_q);

endmodule

// File: tb/tb_ccu_ctrl_mu_arbiter.sv
// Bench for ccu_ctrl_mu_arbiter: a 2-requester instance driven from a vector table
// and a 3-requester, short-starvation instance for urgency corner cases.

module tb_ccu_ctrl_mu_arbiter;
  import ccu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0] a_req;
  logic       a_mu_gnt;
  mu_op_e     a_op     [2];
  logic [7:0] a_holder [2];
  logic [1:0] a_fr     [2];
  logic [1:0] a_gnt;
  logic       a_mu_req;
  mu_op_e     a_mu_op;
  logic [7:0] a_mu_holder;
  logic [1:0] a_mu_fr;
  logic [2:0] a_perf;

  logic [2:0] b_req;
  logic       b_mu_gnt;
  mu_op_e     b_op     [3];
  logic [7:0] b_holder [3];
  logic [1:0] b_fr     [3];
  logic [2:0] b_gnt;
  logic       b_mu_req;
  mu_op_e     b_mu_op;
  logic [7:0] b_mu_holder;
  logic [1:0] b_mu_fr;
  logic [2:0] b_perf;

  ccu_ctrl_mu_arbiter #(
    .NoReq(2), .NoMstPorts(4), .StarveLimit(16), .PerfCounters(1'b1),
    .slv_req_t(logic [7:0])
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(a_req), .op_i(a_op), .holder_i(a_holder),
    .first_responder_i(a_fr), .gnt_o(a_gnt), .mu_req_o(a_mu_req), .mu_op_o(a_mu_op),
    .ccu_req_holder_o(a_mu_holder), .first_responder_o(a_mu_fr), .mu_gnt_i(a_mu_gnt),
    .perf_evt_o(a_perf)
  );

  ccu_ctrl_mu_arbiter #(
    .NoReq(3), .NoMstPorts(4), .StarveLimit(2), .PerfCounters(1'b1),
    .slv_req_t(logic [7:0])
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(b_req), .op_i(b_op), .holder_i(b_holder),
    .first_responder_i(b_fr), .gnt_o(b_gnt), .mu_req_o(b_mu_req), .mu_op_o(b_mu_op),
    .ccu_req_holder_o(b_mu_holder), .first_responder_o(b_mu_fr), .mu_gnt_i(b_mu_gnt),
    .perf_evt_o(b_perf)
  );

  typedef struct packed {
    logic [1:0] req;
    logic       gnt;
    logic       mu;
    logic [1:0] sel;
    logic [1:0] gnt_o;
    logic [2:0] perf;
    logic       ptr;
    logic       lock;
  } vec_a_t;

  typedef struct packed {
    logic [2:0] req;
    logic       gnt;
    logic       mu;
    logic [1:0] sel;
    logic [2:0] gnt_o;
    logic [2:0] perf;
    logic [1:0] ptr;
    logic       lock;
  } vec_b_t;

  vec_a_t vecs [17];
  vec_a_t sb_a [$];
  vec_b_t sb_b [$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle on dut_a, check outputs mid-cycle and state after the edge.
  task automatic run_a(input vec_a_t v, input string tag);
    vec_a_t e;
    a_req    = v.req;
    a_mu_gnt = v.gnt;
    sb_a.push_back(v);
    @(negedge clk);
    e = sb_a.pop_front();
    chk({tag, " mu_req"}, 32'(a_mu_req), 32'(e.mu));
    chk({tag, " gnt"},    32'(a_gnt),    32'(e.gnt_o));
    chk({tag, " perf"},   32'(a_perf),   32'(e.perf));
    chk({tag, " op"},     32'(a_mu_op),     e.mu ? 32'(a_op[e.sel[0]])     : 32'(MU_NOP));
    chk({tag, " holder"}, 32'(a_mu_holder), e.mu ? 32'(a_holder[e.sel[0]]) : 32'd0);
    chk({tag, " fr"},     32'(a_mu_fr),     e.mu ? 32'(a_fr[e.sel[0]])     : 32'd0);
    @(posedge clk);
    #1;
    chk({tag, " rr_ptr"}, 32'(dut_a.rr_ptr_q), 32'(e.ptr));
    chk({tag, " lock"},   32'(dut_a.lock_q),   32'(e.lock));
  endtask

  task automatic run_b(input vec_b_t v, input string tag);
    vec_b_t e;
    b_req    = v.req;
    b_mu_gnt = v.gnt;
    sb_b.push_back(v);
    @(negedge clk);
    e = sb_b.pop_front();
    chk({tag, " mu_req"}, 32'(b_mu_req), 32'(e.mu));
    chk({tag, " gnt"},    32'(b_gnt),    32'(e.gnt_o));
    chk({tag, " perf"},   32'(b_perf),   32'(e.perf));
    chk({tag, " op"},     32'(b_mu_op),     e.mu ? 32'(b_op[e.sel])     : 32'(MU_NOP));
    chk({tag, " holder"}, 32'(b_mu_holder), e.mu ? 32'(b_holder[e.sel]) : 32'd0);
    @(posedge clk);
    #1;
    chk({tag, " rr_ptr"}, 32'(dut_b.rr_ptr_q), 32'(e.ptr));
    chk({tag, " lock"},   32'(dut_b.lock_q),   32'(e.lock));
  endtask

  initial begin
    // {req, gnt, mu, sel, gnt_o, perf{cont,stall,urg}, ptr_after, lock_after}
    vecs[0]  = '{2'b01, 1'b1, 1'b1, 2'd0, 2'b01, 3'b000, 1'b1, 1'b0}; // single requester
    vecs[1]  = '{2'b10, 1'b1, 1'b1, 2'd1, 2'b10, 3'b000, 1'b0, 1'b0};
    vecs[2]  = '{2'b11, 1'b1, 1'b1, 2'd0, 2'b01, 3'b100, 1'b1, 1'b0}; // fairness x6
    vecs[3]  = '{2'b11, 1'b1, 1'b1, 2'd1, 2'b10, 3'b100, 1'b0, 1'b0};
    vecs[4]  = '{2'b11, 1'b1, 1'b1, 2'd0, 2'b01, 3'b100, 1'b1, 1'b0};
    vecs[5]  = '{2'b11, 1'b1, 1'b1, 2'd1, 2'b10, 3'b100, 1'b0, 1'b0};
    vecs[6]  = '{2'b11, 1'b1, 1'b1, 2'd0, 2'b01, 3'b100, 1'b1, 1'b0};
    vecs[7]  = '{2'b11, 1'b1, 1'b1, 2'd1, 2'b10, 3'b100, 1'b0, 1'b0};
    vecs[8]  = '{2'b00, 1'b0, 1'b0, 2'd0, 2'b00, 3'b000, 1'b0, 1'b0}; // idle
    vecs[9]  = '{2'b10, 1'b0, 1'b1, 2'd1, 2'b00, 3'b010, 1'b0, 1'b1}; // lock on 1
    vecs[10] = '{2'b11, 1'b0, 1'b1, 2'd1, 2'b00, 3'b110, 1'b0, 1'b1};
    vecs[11] = '{2'b11, 1'b0, 1'b1, 2'd1, 2'b00, 3'b110, 1'b0, 1'b1};
    vecs[12] = '{2'b11, 1'b1, 1'b1, 2'd1, 2'b10, 3'b100, 1'b0, 1'b0};
    vecs[13] = '{2'b01, 1'b1, 1'b1, 2'd0, 2'b01, 3'b000, 1'b1, 1'b0};
    vecs[14] = '{2'b01, 1'b0, 1'b1, 2'd0, 2'b00, 3'b010, 1'b1, 1'b1}; // lock on 0
    vecs[15] = '{2'b10, 1'b0, 1'b0, 2'd0, 2'b00, 3'b000, 1'b1, 1'b0}; // locked req dropped
    vecs[16] = '{2'b10, 1'b1, 1'b1, 2'd1, 2'b10, 3'b000, 1'b0, 1'b0};

    a_op[0] = MU_READ;  a_op[1] = MU_WRITE;
    a_holder[0] = 8'hA0; a_holder[1] = 8'hB1;
    a_fr[0] = 2'd2; a_fr[1] = 2'd3;
    b_op[0] = MU_READ;  b_op[1] = MU_WRITE; b_op[2] = MU_FLUSH;
    b_holder[0] = 8'hC0; b_holder[1] = 8'hC1; b_holder[2] = 8'hC2;
    b_fr[0] = 2'd1; b_fr[1] = 2'd2; b_fr[2] = 2'd3;
    a_req = '0; a_mu_gnt = 1'b0;
    b_req = '0; b_mu_gnt = 1'b0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset a mu_req", 32'(a_mu_req), 32'd0);
    chk("reset a gnt",    32'(a_gnt),    32'd0);
    chk("reset a op",     32'(a_mu_op),  32'(MU_NOP));
    chk("reset a holder", 32'(a_mu_holder), 32'd0);
    chk("reset a fr",     32'(a_mu_fr),  32'd0);
    chk("reset a perf",   32'(a_perf),   32'd0);
    chk("reset a ptr",    32'(dut_a.rr_ptr_q), 32'd0);
    chk("reset a lock",   32'(dut_a.lock_q),   32'd0);
    chk("reset a sel",    32'(dut_a.sel_q),    32'd0);
    chk("reset b mu_req", 32'(b_mu_req), 32'd0);
    chk("reset b gnt",    32'(b_gnt),    32'd0);
    chk("reset b ptr",    32'(dut_b.rr_ptr_q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) run_a(vecs[i], $sformatf("vec%0d", i));
    a_req = '0;
    a_mu_gnt = 1'b0;

    // Starvation: requester 2 turns urgent behind a lock on 0 and beats rr order.
    run_b('{3'b101, 1'b0, 1'b1, 2'd0, 3'b000, 3'b110, 2'd0, 1'b1}, "starve1");
    run_b('{3'b101, 1'b0, 1'b1, 2'd0, 3'b000, 3'b110, 2'd0, 1'b1}, "starve2");
    chk("starve cnt2", 32'(dut_b.wait_cnt_q[2]), 32'd2);
    run_b('{3'b101, 1'b1, 1'b1, 2'd0, 3'b001, 3'b101, 2'd1, 1'b0}, "starve3");
    run_b('{3'b110, 1'b1, 1'b1, 2'd2, 3'b100, 3'b101, 2'd0, 1'b0}, "starve4");
    run_b('{3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, 2'd0, 1'b0}, "starve5");

    // Reset asserted while locked on requester 1.
    run_a('{2'b01, 1'b1, 1'b1, 2'd0, 2'b01, 3'b000, 1'b1, 1'b0}, "rst_pre0");
    run_a('{2'b10, 1'b0, 1'b1, 2'd1, 2'b00, 3'b010, 1'b1, 1'b1}, "rst_pre1");
    run_a('{2'b11, 1'b0, 1'b1, 2'd1, 2'b00, 3'b110, 1'b1, 1'b1}, "rst_pre2");
    chk("pre-rst cnt1", 32'(dut_a.wait_cnt_q[1]), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst ptr",  32'(dut_a.rr_ptr_q), 32'd0);
    chk("midrst lock", 32'(dut_a.lock_q),   32'd0);
    chk("midrst cnt0", 32'(dut_a.wait_cnt_q[0]), 32'd0);
    chk("midrst cnt1", 32'(dut_a.wait_cnt_q[1]), 32'd0);
    chk("midrst mu_req", 32'(a_mu_req), 32'd1);
    chk("midrst op",   32'(a_mu_op),    32'(a_op[0]));
    chk("midrst gnt",  32'(a_gnt),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    a_req = '0;
    @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
